// File: rtl/dbg_controller.sv
// dbg_controller: debug command sequencer between a serial command decoder and an MCU,
// with a breakpoint table, single/N-step control and a registered paused flag.
// Latency: strobes + out_valid are combinational in the accept cycle, then held while mcu_busy=1.
// Backpressure: ctrlr_busy=1 outside IDLE; in_valid is ignored while busy or on a breakpoint hit.
// Ports: clk/rst; cmd/addr/in_valid command in; pc/mcu_busy from MCU; pause, resume, mcu_reset,
// rf_rd, rf_wr, mem_rd, mem_wr, mem_rw_byte, out_valid request strobes; ctrlr_busy, paused,
// bp_count, bp_err, bp_hit status.
module dbg_controller #(
  parameter int NUM_BP = 8,
  parameter int ADDR_W = 32,
  parameter int STEP_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    cmd,
  input  logic [ADDR_W-1:0]             addr,
  input  logic                          in_valid,
  input  logic [ADDR_W-1:0]             pc,
  input  logic                          mcu_busy,
  output logic                          pause,
  output logic                          resume,
  output logic                          mcu_reset,
  output logic                          rf_rd,
  output logic                          rf_wr,
  output logic                          mem_rd,
  output logic                          mem_wr,
  output logic                          mem_rw_byte,
  output logic                          out_valid,
  output logic                          ctrlr_busy,
  output logic                          paused,
  output logic [$clog2(NUM_BP+1)-1:0]   bp_count,
  output logic                          bp_err,
  output logic                          bp_hit
);

  localparam int CNT_W = $clog2(NUM_BP + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_PAUSE, WAIT_RESUME, WAIT_STEP, WAIT_MEM, WAIT_REG, WAIT_RESET, BREAK_HIT
  } state_t;

  state_t            state_q, state_d;
  logic              paused_q, paused_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [NUM_BP-1:0] bp_vld_q, bp_vld_d;
  logic [ADDR_W-1:0] bp_addr_q [NUM_BP];
  logic [ADDR_W-1:0] bp_addr_d [NUM_BP];
  logic [ADDR_W-1:0] last_hit_q, last_hit_d;
  logic              mask_q, mask_d;
  logic              mem_wr_q, mem_wr_d, mem_byte_q, mem_byte_d, rf_wr_q, rf_wr_d;

  logic              pc_match, addr_match, hit_c, cmd_take, placed;
  logic              pause_c, resume_c, mcu_reset_c, rf_rd_c, rf_wr_c;
  logic              mem_rd_c, mem_wr_c, byte_c, ov_c, bp_err_c;
  logic [CNT_W-1:0]  cnt_c;

  // Breakpoint compare, hit qualification and re-hit mask.
  always_comb begin
    pc_match   = 1'b0;
    addr_match = 1'b0;
    cnt_c      = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_vld_q[i] && bp_addr_q[i] == pc)   pc_match   = 1'b1;
      if (bp_vld_q[i] && bp_addr_q[i] == addr) addr_match = 1'b1;
      cnt_c = cnt_c + CNT_W'(bp_vld_q[i]);
    end
    // Pause/reset in flight or already breaking: the MCU is stopping anyway.
    hit_c = !paused_q && pc_match && !(mask_q && pc == last_hit_q) &&
            state_q != WAIT_PAUSE && state_q != BREAK_HIT && state_q != WAIT_RESET;
    cmd_take = (state_q == IDLE) && in_valid && !hit_c;
    // The mask keeps a resumed MCU sitting on the hit address from re-trapping.
    if (hit_c) begin
      mask_d     = 1'b1;
      last_hit_d = pc;
    end else begin
      mask_d     = mask_q && (pc == last_hit_q);
      last_hit_d = last_hit_q;
    end
  end

  // Breakpoint table maintenance (single-cycle commands).
  always_comb begin
    bp_vld_d  = bp_vld_q;
    bp_addr_d = bp_addr_q;
    bp_err_c  = 1'b0;
    placed    = 1'b0;
    if (cmd_take) begin
      case (cmd)
        4'h9: if (!addr_match) begin
          for (int i = 0; i < NUM_BP; i++) begin
            if (!placed && !bp_vld_q[i]) begin
              bp_vld_d[i]  = 1'b1;
              bp_addr_d[i] = addr;
              placed       = 1'b1;
            end
          end
          bp_err_c = !placed;
        end
        4'hA: begin
          for (int i = 0; i < NUM_BP; i++) begin
            if (bp_vld_q[i] && bp_addr_q[i] == addr) bp_vld_d[i] = 1'b0;
          end
          bp_err_c = !addr_match;
        end
        4'hE:    bp_vld_d = '0;
        default: ;
      endcase
    end
  end

  // Request FSM: next state and strobes.
  always_comb begin
    state_d     = state_q;
    paused_d    = paused_q;
    step_d      = step_q;
    mem_wr_d    = mem_wr_q;
    mem_byte_d  = mem_byte_q;
    rf_wr_d     = rf_wr_q;
    pause_c     = 1'b0;
    resume_c    = 1'b0;
    mcu_reset_c = 1'b0;
    rf_rd_c     = 1'b0;
    rf_wr_c     = 1'b0;
    mem_rd_c    = 1'b0;
    mem_wr_c    = 1'b0;
    byte_c      = 1'b0;
    ov_c        = 1'b0;
    case (state_q)
      IDLE: if (cmd_take) begin
        case (cmd)
          4'h1: begin pause_c = 1'b1; ov_c = 1'b1; state_d = WAIT_PAUSE; end
          4'h2: begin resume_c = 1'b1; ov_c = 1'b1; state_d = WAIT_RESUME; end
          4'h3: if (paused_q) begin
            resume_c = 1'b1;
            ov_c     = 1'b1;
            step_d   = STEP_W'(1);
            state_d  = WAIT_STEP;
          end
          4'h4: begin mcu_reset_c = 1'b1; ov_c = 1'b1; state_d = WAIT_RESET; end
          4'h6, 4'h7, 4'hB, 4'hC: begin
            mem_rd_c   = (cmd == 4'h6) || (cmd == 4'h7);
            mem_wr_c   = (cmd == 4'hB) || (cmd == 4'hC);
            byte_c     = (cmd == 4'h6) || (cmd == 4'hB);
            ov_c       = 1'b1;
            mem_wr_d   = mem_wr_c;
            mem_byte_d = byte_c;
            state_d    = WAIT_MEM;
          end
          4'h8, 4'hD: begin
            rf_rd_c = (cmd == 4'h8);
            rf_wr_c = (cmd == 4'hD);
            ov_c    = 1'b1;
            rf_wr_d = rf_wr_c;
            state_d = WAIT_REG;
          end
          4'hF: if (paused_q && addr[STEP_W-1:0] != '0) begin
            resume_c = 1'b1;
            ov_c     = 1'b1;
            step_d   = addr[STEP_W-1:0];
            state_d  = WAIT_STEP;
          end
          default: ;  // none, status and breakpoint commands finish in IDLE
        endcase
      end
      WAIT_PAUSE: begin
        pause_c = mcu_busy;
        if (!mcu_busy) begin paused_d = 1'b1; state_d = IDLE; end
      end
      WAIT_RESUME: begin
        resume_c = mcu_busy;
        if (!mcu_busy) begin paused_d = 1'b0; state_d = IDLE; end
      end
      WAIT_RESET: begin
        mcu_reset_c = mcu_busy;
        if (!mcu_busy) begin paused_d = 1'b0; state_d = IDLE; end
      end
      WAIT_MEM: begin
        mem_rd_c = mcu_busy && !mem_wr_q;
        mem_wr_c = mcu_busy && mem_wr_q;
        byte_c   = mem_byte_q;
        if (!mcu_busy) state_d = IDLE;
      end
      WAIT_REG: begin
        rf_rd_c = mcu_busy && !rf_wr_q;
        rf_wr_c = mcu_busy && rf_wr_q;
        if (!mcu_busy) state_d = IDLE;
      end
      WAIT_STEP: begin
        if (mcu_busy) begin
          resume_c = 1'b1;
        end else begin
          // One step retired: issue the next resume, or pause after the last one.
          step_d = step_q - STEP_W'(1);
          ov_c   = 1'b1;
          if (step_q == STEP_W'(1)) begin
            pause_c = 1'b1;
            state_d = WAIT_PAUSE;
          end else begin
            resume_c = 1'b1;
          end
        end
      end
      BREAK_HIT: begin pause_c = 1'b1; ov_c = 1'b1; state_d = WAIT_PAUSE; end
      default: state_d = IDLE;
    endcase
    if (hit_c) state_d = BREAK_HIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      paused_q   <= 1'b0;
      step_q     <= '0;
      bp_vld_q   <= '0;
      last_hit_q <= '0;
      mask_q     <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_byte_q <= 1'b0;
      rf_wr_q    <= 1'b0;
      for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      paused_q   <= paused_d;
      step_q     <= step_d;
      bp_vld_q   <= bp_vld_d;
      last_hit_q <= last_hit_d;
      mask_q     <= mask_d;
      mem_wr_q   <= mem_wr_d;
      mem_byte_q <= mem_byte_d;
      rf_wr_q    <= rf_wr_d;
      for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= bp_addr_d[i];
    end
  end

  // Combinational strobes are gated so nothing leaks out while rst is held.
  assign pause       = pause_c     & ~rst;
  assign resume      = resume_c    & ~rst;
  assign mcu_reset   = mcu_reset_c & ~rst;
  assign rf_rd       = rf_rd_c     & ~rst;
  assign rf_wr       = rf_wr_c     & ~rst;
  assign mem_rd      = mem_rd_c    & ~rst;
  assign mem_wr      = mem_wr_c    & ~rst;
  assign mem_rw_byte = byte_c      & ~rst;
  assign out_valid   = ov_c        & ~rst;
  assign bp_err      = bp_err_c    & ~rst;
  assign bp_hit      = hit_c       & ~rst;
  assign ctrlr_busy  = (state_q != IDLE) & ~rst;
  assign paused      = paused_q;
  assign bp_count    = cnt_c;

endmodule

// File: tb/tb_dbg_controller.sv
// tb_dbg_controller: directed stimulus for dbg_controller with a request-level reference model
// compared on every falling edge, plus literal spot checks at key points of each scenario.
module tb_dbg_controller;

  localparam int NUM_BP = 8;
  localparam bit [8:0] P = 9'h001, R = 9'h002, MR = 9'h004, RR = 9'h008, RW = 9'h010,
                       MRD = 9'h020, MWR = 9'h040, BY = 9'h080, OV = 9'h100;

  logic        clk = 1'b0;
  logic        rst, in_valid, mcu_busy;
  logic [3:0]  cmd;
  logic [31:0] addr, pc;
  logic        pause, resume, mcu_reset, rf_rd, rf_wr, mem_rd, mem_wr, mem_rw_byte, out_valid;
  logic        ctrlr_busy, paused, bp_err, bp_hit;
  logic [3:0]  bp_count;

  dbg_controller #(.NUM_BP(NUM_BP), .ADDR_W(32), .STEP_W(16)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .addr(addr), .in_valid(in_valid), .pc(pc),
    .mcu_busy(mcu_busy), .pause(pause), .resume(resume), .mcu_reset(mcu_reset),
    .rf_rd(rf_rd), .rf_wr(rf_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rw_byte(mem_rw_byte), .out_valid(out_valid), .ctrlr_busy(ctrlr_busy),
    .paused(paused), .bp_count(bp_count), .bp_err(bp_err), .bp_hit(bp_hit)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int n_hits = 0, n_resume_req = 0;
  bit saw_mem_rd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the MCU-facing request in flight, the breakpoint set and the paused flag.
  bit          m_paused;
  logic [31:0] m_bps[$];
  bit          m_out;      // a request is outstanding at the MCU
  bit [8:0]    m_hold;     // strobes repeated while mcu_busy
  bit [8:0]    m_sticky;   // strobes shown for the whole outstanding period
  int          m_done_p;   // paused value once the request completes, -1 keeps it
  bit          m_quiet;    // outstanding pause/reset: breakpoints cannot fire
  int          m_steps;    // single steps still to retire
  bit          m_brk;      // break announcement due this cycle
  logic [31:0] m_last;
  bit          m_mask;

  task automatic start(input bit [8:0] hold, input bit [8:0] sticky, input int done_p,
                       input bit quiet);
    m_out = 1'b1; m_hold = hold; m_sticky = sticky; m_done_p = done_p;
    m_quiet = quiet; m_steps = 0;
  endtask

  always @(negedge clk) begin : cmp
    bit [8:0] e_s;
    bit       e_err, e_hit, e_busy, e_paused, match;
    int       e_cnt, found;
    e_s = 9'h0; e_err = 1'b0; e_hit = 1'b0;
    if (mem_rd) saw_mem_rd = 1'b1;
    if (resume && out_valid) n_resume_req++;
    if (bp_hit) n_hits++;
    if (rst) begin
      m_paused = 1'b0; m_bps.delete(); m_out = 1'b0; m_brk = 1'b0; m_steps = 0;
      m_mask = 1'b0; m_last = '0; m_quiet = 1'b0;
      e_busy = 1'b0; e_paused = 1'b0; e_cnt = 0;
    end else begin
      e_busy = m_out || m_brk;
      e_paused = m_paused;
      e_cnt = m_bps.size();
      match = 1'b0;
      foreach (m_bps[i]) if (m_bps[i] == pc) match = 1'b1;
      e_hit = !m_paused && !m_brk && !(m_out && m_quiet) && match && !(m_mask && pc == m_last);
      if (e_hit) begin m_mask = 1'b1; m_last = pc; end
      else if (pc != m_last) m_mask = 1'b0;
      if (m_brk) begin
        e_s = P | OV; m_brk = 1'b0; start(P, 9'h0, 1, 1'b1);
      end else if (m_out) begin
        if (m_steps > 0) begin
          if (mcu_busy) e_s = R;
          else begin
            m_steps--;
            if (m_steps == 0) begin e_s = P | OV; start(P, 9'h0, 1, 1'b1); end
            else e_s = R | OV;
          end
        end else begin
          e_s = (mcu_busy ? m_hold : 9'h0) | m_sticky;
          if (!mcu_busy) begin
            m_out = 1'b0;
            if (m_done_p >= 0) m_paused = (m_done_p != 0);
          end
        end
      end else if (!e_hit && in_valid) begin
        case (cmd)
          4'h1: begin e_s = P | OV; start(P, 9'h0, 1, 1'b1); end
          4'h2: begin e_s = R | OV; start(R, 9'h0, 0, 1'b0); end
          4'h3: if (m_paused) begin e_s = R | OV; start(9'h0, 9'h0, -1, 1'b0); m_steps = 1; end
          4'h4: begin e_s = MR | OV; start(MR, 9'h0, 0, 1'b1); end
          4'h6: begin e_s = MRD | BY | OV; start(MRD, BY, -1, 1'b0); end
          4'h7: begin e_s = MRD | OV; start(MRD, 9'h0, -1, 1'b0); end
          4'h8: begin e_s = RR | OV; start(RR, 9'h0, -1, 1'b0); end
          4'hB: begin e_s = MWR | BY | OV; start(MWR, BY, -1, 1'b0); end
          4'hC: begin e_s = MWR | OV; start(MWR, 9'h0, -1, 1'b0); end
          4'hD: begin e_s = RW | OV; start(RW, 9'h0, -1, 1'b0); end
          4'h9: begin
            found = -1;
            foreach (m_bps[i]) if (m_bps[i] == addr) found = i;
            if (found < 0) begin
              if (m_bps.size() < NUM_BP) m_bps.push_back(addr);
              else e_err = 1'b1;
            end
          end
          4'hA: begin
            found = -1;
            foreach (m_bps[i]) if (m_bps[i] == addr) found = i;
            if (found < 0) e_err = 1'b1;
            else m_bps.delete(found);
          end
          4'hE: m_bps.delete();
          4'hF: if (m_paused && addr[15:0] != 16'h0) begin
            e_s = R | OV; start(9'h0, 9'h0, -1, 1'b0); m_steps = int'(addr[15:0]);
          end
          default: ;
        endcase
      end
      if (e_hit) begin m_brk = 1'b1; m_out = 1'b0; m_steps = 0; end
    end
    chk("cyc_strobes", {23'h0, out_valid, mem_rw_byte, mem_wr, mem_rd, rf_wr, rf_rd,
                        mcu_reset, resume, pause}, {23'h0, e_s});
    chk("cyc_ctrlr_busy", {31'h0, ctrlr_busy}, {31'h0, e_busy});
    chk("cyc_paused", {31'h0, paused}, {31'h0, e_paused});
    chk("cyc_bp_count", {28'h0, bp_count}, 32'(e_cnt));
    chk("cyc_bp_err", {31'h0, bp_err}, {31'h0, e_err});
    chk("cyc_bp_hit", {31'h0, bp_hit}, {31'h0, e_hit});
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a);
    cmd = c; addr = a; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // MCU busy for n cycles, then one idle cycle in which the controller completes.
  task automatic busy_for(input int n);
    mcu_busy = 1'b1;
    repeat (n) step();
    mcu_busy = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; cmd = 4'h0; addr = '0; in_valid = 1'b0; pc = 32'h40; mcu_busy = 1'b0;
    repeat (2) step();
    // Outputs stay quiet during reset even with a command presented.
    cmd = 4'h1; in_valid = 1'b1; settle();
    chk("rst_pause", {31'h0, pause}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_bp_count", {28'h0, bp_count}, 32'h0);
    step();
    in_valid = 1'b0; rst = 1'b0;
    step();

    // Breakpoint at 0x100 fires as pc walks onto it.
    issue(4'h9, 32'h100);
    chk("add_count", {28'h0, bp_count}, 32'd1);
    pc = 32'hFC; step();
    pc = 32'h100; settle();
    chk("hit_pulse", {31'h0, bp_hit}, 32'h1);
    step(); settle();
    chk("break_pause", {30'h0, pause, out_valid}, 32'h3);
    busy_for(2);
    chk("paused_after_break", {31'h0, paused}, 32'h1);

    // Resume with pc parked on the breakpoint: masked until pc moves away.
    issue(4'h2, 32'h0); busy_for(1);
    step(); step();
    chk("no_rehit", {31'h0, bp_hit}, 32'h0);
    pc = 32'h104; step();
    pc = 32'h100; settle();
    chk("rehit", {31'h0, bp_hit}, 32'h1);
    step(); busy_for(1);
    chk("hits_total", 32'(n_hits), 32'd2);

    // Step-N of 3 while paused: three resume requests then a pause.
    pc = 32'h200; n_resume_req = 0;
    issue(4'hF, 32'h0003);
    repeat (3) busy_for(2);
    busy_for(1);
    chk("stepn_resumes", 32'(n_resume_req), 32'd3);
    chk("stepn_paused", {31'h0, paused}, 32'h1);

    // Step-N while running is ignored.
    issue(4'h2, 32'h0); busy_for(1);
    cmd = 4'hF; addr = 32'h3; in_valid = 1'b1; settle();
    chk("stepn_ignored", {30'h0, resume, out_valid}, 32'h0);
    step(); in_valid = 1'b0;
    chk("stepn_ignored_busy", {31'h0, ctrlr_busy}, 32'h0);

    // Single step (code 3) from paused.
    issue(4'h1, 32'h0); busy_for(1);
    issue(4'h3, 32'h0); busy_for(1); busy_for(1);
    chk("step1_paused", {31'h0, paused}, 32'h1);
    issue(4'h2, 32'h0); busy_for(1);

    // Fill the table, overflow, duplicate, remove.
    issue(4'hE, 32'h0);
    for (int i = 0; i < NUM_BP; i++) issue(4'h9, 32'h1000 + 32'(i * 4));
    chk("full_count", {28'h0, bp_count}, 32'd8);
    cmd = 4'h9; addr = 32'h2000; in_valid = 1'b1; settle();
    chk("full_err", {31'h0, bp_err}, 32'h1);
    step();
    addr = 32'h1008; settle();
    chk("dup_no_err", {31'h0, bp_err}, 32'h0);
    step(); in_valid = 1'b0;
    chk("dup_count", {28'h0, bp_count}, 32'd8);
    issue(4'hA, 32'h1004);
    chk("remove_count", {28'h0, bp_count}, 32'd7);
    cmd = 4'hA; addr = 32'h3000; in_valid = 1'b1; settle();
    chk("remove_miss_err", {31'h0, bp_err}, 32'h1);
    step(); in_valid = 1'b0;

    // Hit and mem read in the same cycle: the read is dropped.
    saw_mem_rd = 1'b0;
    pc = 32'h1010; cmd = 4'h7; addr = 32'h80; in_valid = 1'b1; settle();
    chk("race_hit", {31'h0, bp_hit}, 32'h1);
    step(); in_valid = 1'b0; settle();
    chk("race_break", {30'h0, pause, out_valid}, 32'h3);
    busy_for(1);
    chk("race_no_mem_rd", {31'h0, saw_mem_rd}, 32'h0);
    pc = 32'h0;
    issue(4'h2, 32'h0); busy_for(1);

    // Memory/register traffic and MCU reset.
    issue(4'h6, 32'h44);
    mcu_busy = 1'b1; settle();
    chk("memrd_byte_hold", {30'h0, mem_rd, mem_rw_byte}, 32'h3);
    busy_for(2);
    issue(4'hB, 32'h48); busy_for(1);
    issue(4'h7, 32'h4C); busy_for(0);
    issue(4'h8, 32'h3);  busy_for(1);
    issue(4'hD, 32'h5);  busy_for(2);
    issue(4'hC, 32'h50); busy_for(1);
    issue(4'h5, 32'h0);
    issue(4'h1, 32'h0);  busy_for(1);
    issue(4'h4, 32'h0);  busy_for(2);
    chk("mcu_reset_unpaused", {31'h0, paused}, 32'h0);

    // Reset in the middle of a multi-step.
    issue(4'h1, 32'h0); busy_for(1);
    issue(4'hF, 32'h5);
    mcu_busy = 1'b1; step(); step();
    rst = 1'b1; settle();
    chk("midstep_rst_resume", {31'h0, resume}, 32'h0);
    chk("midstep_rst_busy", {31'h0, ctrlr_busy}, 32'h0);
    chk("midstep_rst_count", {28'h0, bp_count}, 32'h0);
    chk("midstep_rst_paused", {31'h0, paused}, 32'h0);
    step();
    rst = 1'b0; mcu_busy = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
